// File: rtl/rps_pkg.sv
// Shared types and the round-judging rule for the rock-paper-scissors blocks.
//   choice_t : 2-bit player choice (11 marks an invalid / forfeit input)
//   result_t : 2-bit round or match outcome
//   state_t  : match controller states
//   judge()  : scores one round from two choices
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    INVALID  = 2'b11
  } choice_t;

  typedef enum logic [1:0] {
    TIE    = 2'b00,
    P1_WIN = 2'b01,
    P2_WIN = 2'b10
  } result_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    SHOW = 2'b10,
    DONE = 2'b11
  } state_t;

  // Equal choices tie (including both invalid); a lone invalid side forfeits.
  function automatic result_t judge(input choice_t a, input choice_t b);
    result_t r;
    logic    a_beats_b;
    a_beats_b = ((a == PAPER)    && (b == ROCK))     ||
                ((a == SCISSORS) && (b == PAPER))    ||
                ((a == ROCK)     && (b == SCISSORS));
    if (a == b) begin
      r = TIE;
    end else if (a == INVALID) begin
      r = P2_WIN;
    end else if (b == INVALID) begin
      r = P1_WIN;
    end else if (a_beats_b) begin
      r = P1_WIN;
    end else begin
      r = P2_WIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge, shared by the match engine and display/AI blocks.
//   a        : player-1 choice
//   b        : player-2 choice
//   result_c : combinational round outcome
module rps_round_judge
  import rps_pkg::*;
(
  input  choice_t a,
  input  choice_t b,
  output result_t result_c
);

  assign result_c = judge(a, b);

endmodule

// File: rtl/rps_match_engine.sv
// Best-of-ROUNDS rock-paper-scissors match controller.
// Captures both choices on a start rising edge, judges the round one cycle
// later, holds the result for SHOW_CYC cycles, and ends the match as soon as
// either player reaches the win target or all rounds are played.
//   clk, rst_n      : clock, asynchronous active-low reset
//   p1_choice       : player-1 choice (00 rock, 01 paper, 10 scissors, 11 invalid)
//   p2_choice       : player-2 choice, same encoding
//   start           : level input; a sampled 0->1 transition requests a round
//   clear           : synchronous abort back to IDLE with all scores zeroed
//   round_valid     : one-cycle pulse when round outputs update
//   round_result    : 00 tie, 01 P1 wins, 10 P2 wins
//   score1, score2  : rounds won by each player
//   round_num       : rounds played, ties included
//   match_done      : high while the match is finished
//   match_winner    : 00 draw/none, 01 P1, 10 P2 (valid with match_done)
//   busy            : high while a round is being evaluated or shown
module rps_match_engine
  import rps_pkg::*;
#(
  parameter  int unsigned ROUNDS   = 5,
  parameter  int unsigned SHOW_CYC = 4,
  localparam int unsigned SW       = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    p1_choice,
  input  logic [1:0]    p2_choice,
  input  logic          start,
  input  logic          clear,
  output logic          round_valid,
  output logic [1:0]    round_result,
  output logic [SW-1:0] score1,
  output logic [SW-1:0] score2,
  output logic [SW-1:0] round_num,
  output logic          match_done,
  output logic [1:0]    match_winner,
  output logic          busy
);

  localparam int unsigned WIN_T = (ROUNDS + 1) / 2;
  localparam int unsigned HW    = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

  state_t        state;
  logic          start_q;
  choice_t       p1_q;
  choice_t       p2_q;
  logic [HW-1:0] hold;

  logic          start_edge_c;
  logic          wipe_c;
  logic          finished_c;
  result_t       res_c;
  result_t       winner_c;

  // Round judge operates on the captured choices only.
  rps_round_judge u_judge (
    .a        (p1_q),
    .b        (p2_q),
    .result_c (res_c)
  );

  assign start_edge_c = start & ~start_q;

  // Clear always wipes; a start edge wipes only when leaving DONE.
  assign wipe_c = clear | ((state == DONE) & start_edge_c);

  assign finished_c = (score1 == SW'(WIN_T)) || (score2 == SW'(WIN_T)) ||
                      (round_num == SW'(ROUNDS));

  always_comb begin
    winner_c = TIE;
    if (score1 > score2) begin
      winner_c = P1_WIN;
    end else if (score2 > score1) begin
      winner_c = P2_WIN;
    end
  end

  // Match FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      p1_q         <= ROCK;
      p2_q         <= ROCK;
      hold         <= '0;
      round_valid  <= 1'b0;
      round_result <= 2'b00;
      score1       <= '0;
      score2       <= '0;
      round_num    <= '0;
      match_done   <= 1'b0;
      match_winner <= 2'b00;
      busy         <= 1'b0;
    end else begin
      start_q     <= start;
      round_valid <= 1'b0;

      if (wipe_c) begin
        state        <= IDLE;
        p1_q         <= ROCK;
        p2_q         <= ROCK;
        hold         <= '0;
        round_result <= 2'b00;
        score1       <= '0;
        score2       <= '0;
        round_num    <= '0;
        match_done   <= 1'b0;
        match_winner <= 2'b00;
        busy         <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_edge_c) begin
              p1_q  <= choice_t'(p1_choice);
              p2_q  <= choice_t'(p2_choice);
              busy  <= 1'b1;
              state <= EVAL;
            end
          end

          EVAL: begin
            round_valid  <= 1'b1;
            round_result <= 2'(res_c);
            round_num    <= round_num + SW'(1);
            if (res_c == P1_WIN) begin
              score1 <= score1 + SW'(1);
            end
            if (res_c == P2_WIN) begin
              score2 <= score2 + SW'(1);
            end
            hold  <= HW'(SHOW_CYC - 1);
            state <= SHOW;
          end

          // Scores updated in EVAL are already visible here, so the
          // end-of-match decision uses the post-round counts.
          SHOW: begin
            if (hold == '0) begin
              busy <= 1'b0;
              if (finished_c) begin
                match_done   <= 1'b1;
                match_winner <= 2'(winner_c);
                state        <= DONE;
              end else begin
                state <= IDLE;
              end
            end else begin
              hold <= hold - HW'(1);
            end
          end

          // Frozen; leaving DONE is handled by the wipe path.
          DONE: begin
            state <= DONE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_match_engine.sv
// Directed self-checking bench for rps_match_engine (5-round and 1-round builds).
module tb_rps_match_engine;

  logic       clk = 1'b0;
  logic       rst_n;

  // Five-round, four-cycle-show instance
  logic       start, clear;
  logic [1:0] p1, p2;
  logic       rv;
  logic [1:0] rr;
  logic [2:0] s1, s2, rn;
  logic       md;
  logic [1:0] mw;
  logic       busy;

  // Single-round, one-cycle-show instance
  logic       start_b, clear_b;
  logic [1:0] p1_b, p2_b;
  logic       rv_b;
  logic [1:0] rr_b;
  logic [0:0] s1_b, s2_b, rn_b;
  logic       md_b;
  logic [1:0] mw_b;
  logic       busy_b;

  int tests  = 0;
  int fails  = 0;
  int rv_cnt = 0;
  int base;

  always #5 clk = ~clk;

  rps_match_engine #(.ROUNDS(5), .SHOW_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .p1_choice(p1), .p2_choice(p2),
    .start(start), .clear(clear), .round_valid(rv), .round_result(rr),
    .score1(s1), .score2(s2), .round_num(rn), .match_done(md),
    .match_winner(mw), .busy(busy)
  );

  rps_match_engine #(.ROUNDS(1), .SHOW_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .p1_choice(p1_b), .p2_choice(p2_b),
    .start(start_b), .clear(clear_b), .round_valid(rv_b), .round_result(rr_b),
    .score1(s1_b), .score2(s2_b), .round_num(rn_b), .match_done(md_b),
    .match_winner(mw_b), .busy(busy_b)
  );

  // Each round_valid pulse spans exactly one falling edge.
  always @(negedge clk) if (rv) rv_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full round from IDLE: start edge, evaluation, four-cycle show.
  task automatic play(input logic [1:0] a, input logic [1:0] b, input logic [1:0] er,
                      input int es1, input int es2, input int ern);
    p1 = a; p2 = b; start = 1'b1;
    tick();
    check("busy_eval", busy, 1);
    check("rv_capture_cycle", rv, 0);
    start = 1'b0; p1 = 2'b11; p2 = 2'b11;   // changes after capture must be ignored
    tick();
    check("rv_pulse", rv, 1);
    check("round_result", rr, er);
    check("score1", s1, es1);
    check("score2", s2, es2);
    check("round_num", rn, ern);
    repeat (4) tick();
    check("busy_after_show", busy, 0);
  endtask

  task automatic leave_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 0; clear = 0; p1 = 0; p2 = 0;
    start_b = 0; clear_b = 0; p1_b = 0; p2_b = 0;
    repeat (3) tick();
    check("rst_rv", rv, 0);
    check("rst_rr", rr, 0);
    check("rst_s1", s1, 0);
    check("rst_s2", s2, 0);
    check("rst_rn", rn, 0);
    check("rst_md", md, 0);
    check("rst_mw", mw, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Paper beats rock three times: early win at 3-0
    base = rv_cnt;
    play(2'b01, 2'b00, 2'b01, 1, 0, 1);
    check("p1_not_done_yet", md, 0);
    play(2'b01, 2'b00, 2'b01, 2, 0, 2);
    play(2'b01, 2'b00, 2'b01, 3, 0, 3);
    check("early_done", md, 1);
    check("early_winner", mw, 2'b01);
    check("three_pulses", rv_cnt - base, 3);
    check("done_frozen_s1", s1, 3);
    leave_done();
    check("done_edge_no_round", rv_cnt - base, 3);
    check("done_edge_s1", s1, 0);
    check("done_edge_rn", rn, 0);
    check("done_edge_md", md, 0);
    check("done_edge_mw", mw, 0);
    check("done_edge_rr", rr, 0);

    // Five ties: match ends on round count with a draw
    for (int i = 1; i <= 5; i++) play(2'b00, 2'b00, 2'b00, 0, 0, i);
    check("tie_done", md, 1);
    check("tie_winner", mw, 2'b00);
    leave_done();

    // Forfeits on invalid input
    play(2'b11, 2'b01, 2'b10, 0, 1, 1);
    play(2'b11, 2'b11, 2'b00, 0, 1, 2);
    play(2'b10, 2'b11, 2'b01, 1, 1, 3);
    check("inv_not_done", md, 0);

    // Start raised inside SHOW and held: no extra round
    base = rv_cnt;
    p1 = 2'b01; p2 = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("show_rv", rv, 1);
    check("show_s1", s1, 2);
    start = 1'b1;
    repeat (6) tick();
    check("held_start_ignored", rv_cnt - base, 1);
    check("held_start_busy", busy, 0);
    check("held_start_rn", rn, 4);
    start = 1'b0;
    tick();
    p1 = 2'b00; p2 = 2'b10; start = 1'b1;   // rock beats scissors
    tick();
    check("toggle_rv_one_clk", rv, 0);
    tick();
    check("toggle_rv_two_clk", rv, 1);
    check("toggle_rr", rr, 2'b01);
    check("toggle_s1", s1, 3);
    check("toggle_rn", rn, 5);
    start = 1'b0;
    repeat (4) tick();
    check("win_3_1_done", md, 1);
    check("win_3_1_winner", mw, 2'b01);
    leave_done();

    // Clear together with a start edge mid-match
    play(2'b10, 2'b01, 2'b01, 1, 0, 1);
    base = rv_cnt;
    clear = 1'b1; start = 1'b1;
    tick();
    check("clr_s1", s1, 0);
    check("clr_rn", rn, 0);
    check("clr_rr", rr, 0);
    check("clr_busy", busy, 0);
    check("clr_rv", rv, 0);
    clear = 1'b0;
    repeat (2) tick();
    check("clr_start_discarded", rv_cnt - base, 0);
    check("clr_busy_after", busy, 0);
    start = 1'b0;
    tick();

    // Asynchronous reset during SHOW
    p1 = 2'b00; p2 = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_s1", s1, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_s1", s1, 0);
    check("async_rn", rn, 0);
    check("async_rr", rr, 0);
    check("async_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // Single-round build: scissors beats paper, done after three clocks
    p1_b = 2'b10; p2_b = 2'b01; start_b = 1'b1;
    tick();
    check("b_busy", busy_b, 1);
    start_b = 1'b0;
    tick();
    check("b_rv", rv_b, 1);
    check("b_not_done", md_b, 0);
    tick();
    check("b_done", md_b, 1);
    check("b_winner", mw_b, 2'b01);
    check("b_s1", s1_b, 1);
    check("b_rn", rn_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
